pcihellocore_hexport_multi: RTL and testbench

Parametrised multi-channel Avalon-MM output port for the PCIe hello core. It drives NUM_CH independent DATA_W-bit output channels, typically active-low seven-segment banks. Each channel supports byte-enabled writes, atomic bit set and clear, and a per-bit blink mask. A shared, programmable blink timer drives the blink masks, and all outputs are registered for glitch-free pin drive.

---
 rtl/pcihellocore_hexport_pkg.sv | 37 +++
 rtl/pcihellocore_blink_timer.sv | 64 ++++++
 rtl/pcihellocore_hexport_multi.sv | 150 +++++++++++++++
 tb/tb_pcihellocore_hexport_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_hexport_pkg.sv
// -----------------------------------------------------------------------------
// pcihellocore_hexport_pkg
// Shared definitions for the multi-channel hex output port:
//   - per-channel function codes (address[1:0] when global=0)
//   - global-space function codes (address[1:0] when global=1)
//   - STATUS register bit position
//   - bytemask(): expands byte enables into a 32-bit lane mask
// -----------------------------------------------------------------------------
package pcihellocore_hexport_pkg;

  typedef enum logic [1:0] {
    FN_DATA     = 2'd0,
    FN_OUTSET   = 2'd1,
    FN_OUTCLEAR = 2'd2,
    FN_MASK     = 2'd3
  } fn_e;

  typedef enum logic [1:0] {
    GF_PERIOD = 2'd0,
    GF_STATUS = 2'd1,
    GF_RSVD2  = 2'd2,
    GF_RSVD3  = 2'd3
  } gf_e;

  localparam int STATUS_PHASE_BIT = 0;

  // Each enabled byte lane becomes 8 ones; callers keep only the low DATA_W bits.
  function automatic logic [31:0] bytemask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pcihellocore_blink_timer.sv
// -----------------------------------------------------------------------------
// pcihellocore_blink_timer
// Programmable blink timer shared by all channels. Holds the period register,
// a free-running counter and the blink phase.
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   period_we_i    : period register write strobe
//   period_wdata_i : new period value
//   phase_o        : blink phase (toggles every period+1 cycles)
//   period_o       : current period, for readback
// -----------------------------------------------------------------------------
module pcihellocore_blink_timer #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  period_we_i,
  input  logic [PRESCALE_W-1:0] period_wdata_i,
  output logic                  phase_o,
  output logic [PRESCALE_W-1:0] period_o
);

  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  // Timer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Next-state: a period write takes priority over the wrap so it never toggles
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (period_we_i) begin
      period_d = period_wdata_i;
      cnt_d    = '0;
      // Disabling the timer also parks the phase in its "visible" state.
      phase_d  = (period_wdata_i == '0) ? 1'b0 : phase_q;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PRESCALE_W'(1);
    end
  end

  assign phase_o  = phase_q;
  assign period_o = period_q;

endmodule

// File: rtl/pcihellocore_hexport_multi.sv
// -----------------------------------------------------------------------------
// pcihellocore_hexport_multi
// Multi-channel Avalon-MM output port with byte-enabled writes, atomic bit
// set/clear, per-bit blink masks and a shared blink timer.
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   address    : {global, ch[CH_AW-1:0], func[1:0]}
//   chipselect : Avalon select
//   write_n    : active-low write strobe
//   writedata  : write data
//   byteenable : write byte lanes
//   readdata   : combinational read data (address decoded only)
//   out_port   : registered channel outputs, channel c at [c*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module pcihellocore_hexport_multi
  import pcihellocore_hexport_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL  = '1,
  parameter int                PRESCALE_W = 24,
  localparam int               CH_AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CH_AW+2:0]         address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [DATA_W/8-1:0]      byteenable,
  output logic [DATA_W-1:0]        readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);

  localparam logic [CH_AW:0] NUM_CH_W = (CH_AW+1)'(NUM_CH);

  logic [DATA_W-1:0]        data_q [NUM_CH];
  logic [DATA_W-1:0]        data_d [NUM_CH];
  logic [DATA_W-1:0]        mask_q [NUM_CH];
  logic [DATA_W-1:0]        mask_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] out_q, out_d;

  logic                  global_s;
  logic [CH_AW-1:0]      ch_s;
  logic [1:0]            func_s;
  logic                  wr_s;
  logic                  ch_valid_s;
  logic                  ch_wr_s;
  logic                  period_we_s;
  logic [3:0]            be4_s;
  logic [31:0]           bm32_s;
  logic [DATA_W-1:0]     bm_s;
  logic [DATA_W-1:0]     m_s;
  logic [DATA_W-1:0]     rd_s;
  logic                  phase_s;
  logic [PRESCALE_W-1:0] period_s;

  assign global_s    = address[CH_AW+2];
  assign ch_s        = address[CH_AW+1:2];
  assign func_s      = address[1:0];
  assign wr_s        = chipselect & ~write_n;
  assign ch_valid_s  = ({1'b0, ch_s} < NUM_CH_W);
  assign ch_wr_s     = wr_s & ~global_s & ch_valid_s;
  assign period_we_s = wr_s & global_s & (func_s == GF_PERIOD);

  assign be4_s  = 4'(byteenable);
  assign bm32_s = bytemask(be4_s);
  assign bm_s   = bm32_s[DATA_W-1:0];
  assign m_s    = writedata & bm_s;

  pcihellocore_blink_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .period_we_i    (period_we_s),
    .period_wdata_i (PRESCALE_W'(writedata)),
    .phase_o        (phase_s),
    .period_o       (period_s)
  );

  // Channel register updates; OUTSET/OUTCLEAR are single-cycle read-modify-write
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (ch_wr_s) begin
      case (fn_e'(func_s))
        FN_DATA:     data_d[ch_s] = (data_q[ch_s] & ~bm_s) | m_s;
        FN_OUTSET:   data_d[ch_s] = data_q[ch_s] | m_s;
        FN_OUTCLEAR: data_d[ch_s] = data_q[ch_s] & ~m_s;
        FN_MASK:     mask_d[ch_s] = (mask_q[ch_s] & ~bm_s) | m_s;
        default:     data_d       = data_q;
      endcase
    end else begin
      data_d = data_q;
      mask_d = mask_q;
    end
  end

  // Output stage: blinking bits show RESET_VAL ("off") while phase is high
  always_comb begin
    out_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (phase_s) begin
        out_d[c*DATA_W +: DATA_W] = (data_q[c] & ~mask_q[c]) | (RESET_VAL & mask_q[c]);
      end else begin
        out_d[c*DATA_W +: DATA_W] = data_q[c];
      end
    end
  end

  // Channel registers and registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= RESET_VAL;
        mask_q[c] <= '0;
      end
      out_q <= {NUM_CH{RESET_VAL}};
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      out_q  <= out_d;
    end
  end

  // Read mux: decoded from address alone, no chipselect qualification
  always_comb begin
    rd_s = '0;
    if (global_s) begin
      case (gf_e'(func_s))
        GF_PERIOD: rd_s = DATA_W'(period_s);
        GF_STATUS: rd_s[STATUS_PHASE_BIT] = phase_s;
        default:   rd_s = '0;
      endcase
    end else if (ch_valid_s) begin
      case (fn_e'(func_s))
        FN_DATA: rd_s = data_q[ch_s];
        FN_MASK: rd_s = mask_q[ch_s];
        default: rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  assign readdata = rd_s;
  assign out_port = out_q;

endmodule

// File: tb/tb_pcihellocore_hexport_multi.sv
// -----------------------------------------------------------------------------
// Bench for pcihellocore_hexport_multi. Two instances share one bus: u_dut with
// default parameters (4 channels) and u_dut3 with 3 channels, so the unmapped
// channel 3 can be exercised. A behavioural model tracks both instances and is
// compared every cycle; directed checks pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_pcihellocore_hexport_multi;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [4:0]   address    = 5'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [31:0]  writedata  = 32'h0;
  logic [3:0]   byteenable = 4'h0;
  logic [31:0]  rd4, rd3;
  logic [127:0] out4;
  logic [95:0]  out3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pcihellocore_hexport_multi u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (rd4),
    .out_port   (out4)
  );

  pcihellocore_hexport_multi #(.NUM_CH(3)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (rd3),
    .out_port   (out3)
  );

  // ---------------- behavioural model (index 0: 4 channels, 1: 3 channels)
  logic [31:0] md [2][4];
  logic [31:0] mm [2][4];
  logic [31:0] mo [2][4];
  int          mper [2];
  int          mcnt [2];
  bit          mph  [2];

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) r = r | (32'hFF << (8*b));
    return r;
  endfunction

  function automatic logic [31:0] mread(input int i);
    int ch;
    ch = int'(address[3:2]);
    if (address[4]) begin
      if (address[1:0] == 2'd0) return 32'(mper[i]);
      if (address[1:0] == 2'd1) return {31'd0, mph[i]};
      return 32'h0;
    end
    if (ch >= nch(i)) return 32'h0;
    if (address[1:0] == 2'd0) return md[i][ch];
    if (address[1:0] == 2'd3) return mm[i][ch];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin : mdl
    logic        wr_v;
    logic [31:0] bm_v, m_v;
    int          ch_v;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mper[i] <= 0; mcnt[i] <= 0; mph[i] <= 1'b0;
        for (int c = 0; c < 4; c++) begin
          md[i][c] <= 32'hFFFF_FFFF; mm[i][c] <= 32'h0; mo[i][c] <= 32'hFFFF_FFFF;
        end
      end
    end else begin
      wr_v = chipselect && !write_n;
      bm_v = bmask(byteenable);
      m_v  = writedata & bm_v;
      ch_v = int'(address[3:2]);
      for (int i = 0; i < 2; i++) begin
        // blinking bits are forced to the all-ones "off" value
        for (int c = 0; c < nch(i); c++) mo[i][c] <= mph[i] ? (md[i][c] | mm[i][c]) : md[i][c];
        if (wr_v && address[4] && address[1:0] == 2'd0) begin
          mper[i] <= int'(writedata[23:0]);
          mcnt[i] <= 0;
          if (writedata[23:0] == 24'd0) mph[i] <= 1'b0;
        end else if (mper[i] == 0) begin
          mcnt[i] <= 0; mph[i] <= 1'b0;
        end else if (mcnt[i] + 1 > mper[i]) begin
          mcnt[i] <= 0; mph[i] <= !mph[i];
        end else begin
          mcnt[i] <= mcnt[i] + 1;
        end
        if (wr_v && !address[4] && ch_v < nch(i)) begin
          case (address[1:0])
            2'd0: md[i][ch_v] <= (md[i][ch_v] & ~bm_v) | m_v;
            2'd1: md[i][ch_v] <= md[i][ch_v] | m_v;
            2'd2: md[i][ch_v] <= md[i][ch_v] & ~m_v;
            default: mm[i][ch_v] <= (mm[i][ch_v] & ~bm_v) | m_v;
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model, 2 time units after the edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int c = 0; c < 4; c++) chk($sformatf("model_out4_ch%0d", c), out4[c*32 +: 32], mo[0][c]);
      for (int c = 0; c < 3; c++) chk($sformatf("model_out3_ch%0d", c), out3[c*32 +: 32], mo[1][c]);
      chk("model_rd4", rd4, mread(0));
      chk("model_rd3", rd3, mread(1));
    end
  end

  // ---------------- stimulus helpers (called between negedge and posedge)
  task automatic wr(input logic g, input logic [1:0] ch, input logic [1:0] fn,
                    input logic [31:0] d, input logic [3:0] be);
    address = {g, ch, fn}; chipselect = 1'b1; write_n = 1'b0; writedata = d; byteenable = be;
    @(negedge clk);
  endtask

  task automatic idle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic setaddr(input logic g, input logic [1:0] ch, input logic [1:0] fn);
    address = {g, ch, fn};
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // reset values
    for (int c = 0; c < 4; c++) chk("reset_out", out4[c*32 +: 32], 32'hFFFF_FFFF);
    setaddr(1'b0, 2'd2, 2'd0);
    chk("reset_rd_ch2", rd4, 32'hFFFF_FFFF);

    // byte-enabled DATA write
    wr(1'b0, 2'd1, 2'd0, 32'h1234_5678, 4'b0101);
    idle();
    setaddr(1'b0, 2'd1, 2'd0);
    chk("data_be_rd", rd4, 32'hFF34_FF78);
    chk("data_be_out_before", out4[32 +: 32], 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("data_be_out_after", out4[32 +: 32], 32'hFF34_FF78);

    // back-to-back OUTCLEAR / OUTSET
    wr(1'b0, 2'd0, 2'd2, 32'h0000_00FF, 4'hF);
    wr(1'b0, 2'd0, 2'd1, 32'h0000_000F, 4'hF);
    idle();
    setaddr(1'b0, 2'd0, 2'd0);
    chk("clr_set_rd", rd4, 32'hFFFF_FF0F);
    setaddr(1'b0, 2'd0, 2'd1);
    chk("outset_rd_zero", rd4, 32'h0);
    setaddr(1'b0, 2'd0, 2'd2);
    chk("outclear_rd_zero", rd4, 32'h0);

    // channel 3: mapped in u_dut, unmapped in u_dut3
    wr(1'b0, 2'd3, 2'd0, 32'hA5A5_A5A5, 4'hF);
    idle();
    setaddr(1'b0, 2'd3, 2'd0);
    chk("oor_rd3_zero", rd3, 32'h0);
    chk("oor_rd4_ch3", rd4, 32'hA5A5_A5A5);
    @(negedge clk); #1;
    chk("oor_out3_ch0", out3[0 +: 32], 32'hFFFF_FF0F);
    chk("oor_out3_ch1", out3[32 +: 32], 32'hFF34_FF78);
    chk("oor_out3_ch2", out3[64 +: 32], 32'hFFFF_FFFF);

    // blink: ch3 data 0, mask 0xFF, period 3 -> 4-cycle half period
    @(negedge clk);
    wr(1'b0, 2'd3, 2'd0, 32'h0, 4'hF);
    wr(1'b0, 2'd3, 2'd3, 32'h0000_00FF, 4'hF);
    wr(1'b1, 2'd0, 2'd0, 32'd3, 4'h0);
    idle();
    setaddr(1'b1, 2'd0, 2'd1);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("blink_status_j%0d", j), rd4, 32'((j / 4) % 2));
      chk($sformatf("blink_out_j%0d", j), out4[96 +: 32], (((j - 1) / 4) % 2 == 1) ? 32'hFF : 32'h0);
      @(negedge clk); #1;
    end

    // PERIOD rewrite exactly on the wrap edge: no toggle, counter restarts
    repeat (3) @(negedge clk);
    wr(1'b1, 2'd0, 2'd0, 32'd3, 4'hF);
    idle();
    setaddr(1'b1, 2'd0, 2'd1);
    chk("wrap_no_toggle", rd4, 32'h0);
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk); #1;
      chk($sformatf("wrap_restart_m%0d", m), rd4, (m == 4) ? 32'h1 : 32'h0);
    end

    // PERIOD=0 while phase=1: phase forced low, output unmasks one edge later
    wr(1'b1, 2'd0, 2'd0, 32'd0, 4'hF);
    idle();
    setaddr(1'b1, 2'd0, 2'd1);
    chk("p0_phase_cleared", rd4, 32'h0);
    chk("p0_out_still_masked", out4[96 +: 32], 32'h0000_00FF);
    @(negedge clk); #1;
    chk("p0_out_unmasked", out4[96 +: 32], 32'h0);
    chk("p0_phase_held", rd4, 32'h0);
    setaddr(1'b1, 2'd0, 2'd0);
    chk("p0_period_rd", rd4, 32'h0);

    // asynchronous reset mid-blink
    wr(1'b1, 2'd0, 2'd0, 32'd1, 4'hF);
    idle();
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) chk("async_rst_out4", out4[c*32 +: 32], 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) chk("async_rst_out3", out3[c*32 +: 32], 32'hFFFF_FFFF);
    setaddr(1'b0, 2'd3, 2'd0);
    chk("async_rst_rd_data", rd4, 32'hFFFF_FFFF);
    setaddr(1'b0, 2'd3, 2'd3);
    chk("async_rst_rd_mask", rd4, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // first write right after deassertion is accepted
    wr(1'b0, 2'd0, 2'd0, 32'h0000_0000, 4'hF);
    idle();
    setaddr(1'b0, 2'd0, 2'd0);
    chk("post_rst_first_write", rd4, 32'h0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
